// File: rtl/bridge_pkg.sv
// Shared bridge definitions: PWM widths, PWM state encoding and the register map
// offsets that feed the PWM stage.
package bridge_pkg;

  localparam int PWM_CNT_W = 32;
  localparam int PWM_DIV_W = 5;

  typedef enum logic {
    PWM_IDLE = 1'b0,
    PWM_RUN  = 1'b1
  } pwm_state_e;

  localparam logic [7:0] REG_DBG      = 8'h0C;
  localparam logic [7:0] REG_PWM_DIV  = 8'h20;
  localparam logic [7:0] REG_PWM_DUTY = 8'h24;
  localparam int         DBG_PWM_EN_BIT = 6;

endpackage

// File: rtl/pwm_duty_generator.sv
// PWM generator with a 2^div cycle period and double-buffered divider/duty settings
// that are only adopted at a period boundary.
module pwm_duty_generator
  import bridge_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int DIV_W = PWM_DIV_W
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             en,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic [CNT_W-1:0] duty_cfg,
  input  logic             cfg_update,
  output logic             pwm_out,
  output logic             period_start,
  output logic [CNT_W-1:0] cnt,
  output logic [DIV_W-1:0] div_sh,
  output logic [CNT_W-1:0] duty_sh,
  output logic             running
);

  // Bit-by-bit build keeps the mask well defined even when div >= CNT_W.
  function automatic logic [CNT_W-1:0] period_mask(input logic [DIV_W-1:0] d);
    logic [CNT_W-1:0] m;
    m = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < int'(d)) m[i] = 1'b1;
    end
    return m;
  endfunction

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             terminal;
  logic             pending_any;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q        <= PWM_IDLE;
      cnt_q          <= '0;
      div_sh_q       <= '0;
      duty_sh_q      <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_sh_q       <= div_sh_d;
      duty_sh_q      <= duty_sh_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PWM_IDLE: if (en)  state_d = PWM_RUN;
      PWM_RUN:  if (!en) state_d = PWM_IDLE;
      default:           state_d = PWM_IDLE;
    endcase
  end

  assign terminal    = (cnt_q == period_mask(div_sh_q));
  assign pending_any = pending_q | cfg_update;

  // Counter, shadows and the registered outputs all derive from next-state values
  // so pwm_out and period_start line up with the cnt they describe.
  always_comb begin
    cnt_d          = '0;
    div_sh_d       = div_sh_q;
    duty_sh_d      = duty_sh_q;
    pending_d      = 1'b0;
    pwm_d          = 1'b0;
    period_start_d = 1'b0;
    if (state_q == PWM_IDLE) begin
      div_sh_d  = div_cfg;
      duty_sh_d = duty_cfg;
      if (state_d == PWM_RUN) begin
        period_start_d = 1'b1;
        pwm_d          = (cnt_d < duty_sh_d);
      end
    end else if (state_d == PWM_RUN) begin
      cnt_d     = terminal ? '0 : cnt_q + CNT_W'(1);
      pending_d = pending_any;
      if (terminal && pending_any) begin
        div_sh_d  = div_cfg;
        duty_sh_d = duty_cfg;
        pending_d = 1'b0;
      end
      period_start_d = (cnt_d == '0);
      pwm_d          = (cnt_d < duty_sh_d);
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign cnt          = cnt_q;
  assign div_sh       = div_sh_q;
  assign duty_sh      = duty_sh_q;
  assign running      = (state_q == PWM_RUN);

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Directed bench for pwm_duty_generator: default-width instance plus a narrow
// instance that reaches the largest divider and its counter wrap in few cycles.
module tb_pwm_duty_generator;
  import bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  div_cfg;
  logic [31:0] duty_cfg;
  logic        cfg_update;
  logic        pwm_out, period_start, running;
  logic [31:0] cnt, duty_sh;
  logic [4:0]  div_sh;

  logic        en2;
  logic [2:0]  div2;
  logic [7:0]  duty2;
  logic        cfg2;
  logic        pwm2, ps2, run2;
  logic [7:0]  cnt2, duty_sh2;
  logic [2:0]  div_sh2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_generator dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .en(en), .div_cfg(div_cfg),
    .duty_cfg(duty_cfg), .cfg_update(cfg_update), .pwm_out(pwm_out),
    .period_start(period_start), .cnt(cnt), .div_sh(div_sh), .duty_sh(duty_sh),
    .running(running)
  );

  pwm_duty_generator #(.CNT_W(8), .DIV_W(3)) dut_small (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .en(en2), .div_cfg(div2),
    .duty_cfg(duty2), .cfg_update(cfg2), .pwm_out(pwm2),
    .period_start(ps2), .cnt(cnt2), .div_sh(div_sh2), .duty_sh(duty_sh2),
    .running(run2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Park in IDLE long enough for the shadows to take the new settings, then start.
  task automatic run_cfg(input logic [4:0] d, input logic [31:0] duty);
    en       = 1'b0;
    div_cfg  = d;
    duty_cfg = duty;
    step();
    step();
    en = 1'b1;
    step();
  endtask

  task automatic check_run(input string tag, input int n, input int d,
                           input logic [31:0] duty, input int start);
    longint c;
    for (int i = 0; i < n; i++) begin
      c = (longint'(start) + i) % (longint'(1) << d);
      chk({tag, "_cnt"}, 64'(cnt), 64'(c));
      chk({tag, "_pwm"}, 64'(pwm_out), 64'(c < longint'(duty)));
      chk({tag, "_ps"},  64'(period_start), 64'(c == 0));
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_cfg = 5'd2; duty_cfg = 32'd1; cfg_update = 1'b0;
    en2 = 1'b0; div2 = 3'd7; duty2 = 8'd64; cfg2 = 1'b0;
    step(); step();
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_pwm", 64'(pwm_out), 64'd0);
    chk("rst_ps", 64'(period_start), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_div_sh", 64'(div_sh), 64'd0);
    chk("rst_duty_sh", 64'(duty_sh), 64'd0);

    rst_n = 1'b1;
    step();
    chk("idle_div_sh", 64'(div_sh), 64'd2);
    chk("idle_duty_sh", 64'(duty_sh), 64'd1);
    chk("idle_running", 64'(running), 64'd0);
    en = 1'b1;
    step();
    chk("start_running", 64'(running), 64'd1);
    check_run("d2", 9, 2, 32'd1, 0);

    run_cfg(5'd3, 32'd0);
    check_run("duty0", 10, 3, 32'd0, 0);
    run_cfg(5'd3, 32'd8);
    check_run("duty8", 10, 3, 32'd8, 0);
    run_cfg(5'd3, 32'hFFFF_FFFF);
    check_run("dutymax", 10, 3, 32'hFFFF_FFFF, 0);

    // Mid-period write at cnt=3 must not disturb the running period.
    run_cfg(5'd3, 32'd2);
    check_run("mid_a", 3, 3, 32'd2, 0);
    chk("mid_cnt3", 64'(cnt), 64'd3);
    duty_cfg = 32'd6; cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("mid_hold_sh", 64'(duty_sh), 64'd2);
    check_run("mid_b", 4, 3, 32'd2, 4);
    chk("mid_new_sh", 64'(duty_sh), 64'd6);
    check_run("mid_c", 7, 3, 32'd6, 0);
    chk("term_cnt7", 64'(cnt), 64'd7);
    duty_cfg = 32'd3; cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("term_new_sh", 64'(duty_sh), 64'd3);
    check_run("term", 8, 3, 32'd3, 0);

    run_cfg(5'd0, 32'd1);
    check_run("div0", 5, 0, 32'd1, 0);

    run_cfg(5'd31, 32'h4000_0000);
    chk("div31_sh", 64'(div_sh), 64'd31);
    check_run("div31", 4, 31, 32'h4000_0000, 0);

    // en dropped mid-period, then a fresh period on re-enable.
    run_cfg(5'd4, 32'd10);
    check_run("drop_pre", 5, 4, 32'd10, 0);
    chk("drop_cnt5", 64'(cnt), 64'd5);
    en = 1'b0;
    step();
    chk("drop_cnt", 64'(cnt), 64'd0);
    chk("drop_pwm", 64'(pwm_out), 64'd0);
    chk("drop_running", 64'(running), 64'd0);
    chk("drop_ps", 64'(period_start), 64'd0);
    en = 1'b1;
    step();
    chk("reen_running", 64'(running), 64'd1);
    check_run("reen", 4, 4, 32'd10, 0);

    // Narrow build: largest divider, wrap from mask to 0 and the duty fall edge.
    en2 = 1'b1;
    step();
    for (int i = 0; i < 130; i++) begin
      if (i == 63 || i == 64 || i == 127 || i == 128 || i == 0) begin
        chk("small_cnt", 64'(cnt2), 64'(i % 128));
        chk("small_pwm", 64'(pwm2), 64'((i % 128) < 64));
        chk("small_ps", 64'(ps2), 64'((i % 128) == 0));
      end
      step();
    end

    // Asynchronous reset between clock edges.
    run_cfg(5'd3, 32'd5);
    step(); step();
    chk("arst_pre_pwm", 64'(pwm_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_pwm", 64'(pwm_out), 64'd0);
    chk("arst_running", 64'(running), 64'd0);
    chk("arst_duty_sh", 64'(duty_sh), 64'd0);
    chk("arst_div_sh", 64'(div_sh), 64'd0);
    en = 1'b0; div_cfg = 5'd2; duty_cfg = 32'd5;
    step();
    rst_n = 1'b1;
    step();
    chk("rel_div_sh", 64'(div_sh), 64'd2);
    chk("rel_duty_sh", 64'(duty_sh), 64'd5);
    chk("rel_running", 64'(running), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_generator.md
# pwm_duty_generator

Programmable PWM generator for the bridge: the stage directly downstream of the AXI-Lite register file. It consumes the PWM divider register (offset 0x20) and the duty-cycle register (offset 0x24), gated by the PWM-enable bit of the debug register (offset 0xC, bit 6). It produces a glitch-free PWM waveform whose period is 2^div clock cycles. New settings are double-buffered and take effect only at a period boundary.

## Interface
- `CNT_W`, default 32: counter and duty width.
- `DIV_W`, default 5: divider exponent width; period = 2^div, div ∈ 0..31.
- `S_AXI_ACLK`  in  1: sole clock, rising edge.
- `S_AXI_ARESETN`  in  1: reset; asynchronous assert, active-low.
- `en`  in  1: PWM enable (debug reg bit 6), level.
- `div_cfg`  in  DIV_W: period exponent (reg 0x20 bits 4:0).
- `duty_cfg`  in  CNT_W: high-time in cycles (reg 0x24).
- `cfg_update`  in  1: one-cycle pulse when 0x20 or 0x24 is written.
- `pwm_out`  out  1: PWM waveform, registered.
- `period_start`  out  1: one-cycle pulse on every cycle with cnt==0 while running.
- `cnt`  out  CNT_W: current period counter.
- `div_sh`  out  DIV_W: active (shadow) divider.
- `duty_sh`  out  CNT_W: active (shadow) duty.
- `running`  out  1: state==RUN.

## Operation
- States: IDLE and RUN.
  - IDLE→RUN when en=1.
  - RUN→IDLE when en=0, evaluated every cycle, mid-period included.
- IDLE:
  - cnt=0, pwm_out=0, period_start=0, pending=0.
  - Shadows load div_cfg/duty_cfg every cycle.
- RUN:
  - mask = (1<<div_sh)−1, computed in CNT_W bits; div_sh=31 gives 0x7FFF_FFFF.
  - cnt increments each cycle.
  - At cnt==mask (terminal), cnt wraps to 0.
- Shadow update:
  - cfg_update sets a pending flag.
  - At terminal with pending=1, shadows load the live div_cfg/duty_cfg and pending clears.
  - Terminal and cfg_update in the same cycle: load occurs, pending ends 0.
  - A mid-period write never alters the current period.
- Output:
  - pwm_out = (cnt < duty_sh), unsigned, aligned to the same cycle as cnt, i.e. computed from the next-state values and registered.
  - duty_sh=0 → always low.
  - duty_sh ≥ 2^div_sh → always high.
- div_sh=0: period of 1 cycle; cnt stays 0; period_start high every RUN cycle; pwm_out = (duty_sh≠0).

## Timing
- Reset (async, active-low): state=IDLE, cnt=0, pwm_out=0, period_start=0, running=0, div_sh=0, duty_sh=0, pending=0.
- Reset deassertion is used synchronously; reset mid-period returns immediately to reset values.
- en rises in cycle t → in cycle t+1: running=1, cnt=0, period_start=1, pwm_out=(0<duty_sh). The shadows used are those loaded in cycle t.
- en falls in cycle t → in cycle t+1: IDLE values; no partial-period completion.
- Config write in period P → first effect on the cycle where cnt==0 of period P+1.
- No handshake back-pressure; cfg_update is never lost.

## Structure
- Shared package `bridge_pkg`: `PWM_CNT_W`, `PWM_DIV_W`, PWM state enum (`PWM_IDLE`, `PWM_RUN`), register offsets `REG_DBG=0xC`, `REG_PWM_DIV=0x20`, `REG_PWM_DUTY=0x24`, `DBG_PWM_EN_BIT=6`.
- Single module, no sub-module. The mask generator stays an inline function.

## Test plan
- Reset held, then en=1, div=2, duty=1 → pwm_out repeats 1,0,0,0; period_start every 4th cycle; cnt 0,1,2,3,0.
- duty=0 (div=3) → pwm_out constant 0. duty=8 or duty=0xFFFF_FFFF (div=3) → constant 1.
- Running div=3, duty=2; at cnt=3 write duty=6 with a cfg_update pulse → rest of the period keeps 2 high cycles; the next period shows 6 high then 2 low. cfg_update coincident with cnt=7 → the new value applies at the next cnt=0.
- div=0, duty=1 → pwm_out constant 1 and period_start constant 1. div=31, duty=2^30 → cnt passes 0x7FFF_FFFF→0, pwm_out falls at cnt=2^30 (shorten with forced count check or a reduced CNT_W build).
- en dropped at cnt=5 (div=4) → next cycle cnt=0, pwm_out=0, running=0. Re-enable → fresh period starting at cnt=0.
- S_AXI_ARESETN asserted asynchronously mid-period → outputs zero without waiting for a clock edge. Shadows reload from inputs in IDLE after release.
